// File: rtl/ysyx_23060191_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ysyx_23060191_mem_arbiter
// Brief    : Shares the data-memory port between IFU fetches and LSU accesses,
//            one transaction outstanding, with a timeout watchdog.
//            Define YSYX_ARB_RR_EN for round-robin arbitration (default: LSU
//            fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060191_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_req_ready,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_rdata,
    output logic                  lsu_rsp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    input  logic                  mem_rsp_err
);

    localparam int          c_MASK_W   = DATA_W / 8;
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE = 2'd1;
    localparam logic [1:0]  c_ST_WAIT  = 2'd2;
    localparam logic        c_OWN_IFU  = 1'b0;
    localparam logic        c_OWN_LSU  = 1'b1;
    localparam bit          c_WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]           r_state;
    logic                 r_owner;
    logic                 r_req_valid;
    logic                 r_wen;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_MASK_W-1:0]  r_wmask;
    logic [CNT_W-1:0]     r_wdog;

    logic                 r_ifu_rsp_valid;
    logic [DATA_W-1:0]    r_ifu_rsp_data;
    logic                 r_ifu_rsp_err;
    logic                 r_lsu_rsp_valid;
    logic [DATA_W-1:0]    r_lsu_rsp_rdata;
    logic                 r_lsu_rsp_err;

`ifdef YSYX_ARB_RR_EN
    logic                 r_last_grant;
`endif

    logic                 w_idle_free;
    logic                 w_pick_lsu;
    logic                 w_grant;
    logic                 w_timeout;
    logic                 w_rsp_fire;
    logic [DATA_W-1:0]    w_rsp_data;
    logic                 w_rsp_err;

    // The response cycle still sits in IDLE, so grants wait for the pulse to clear.
    assign w_idle_free = (r_state == c_ST_IDLE) && !r_ifu_rsp_valid && !r_lsu_rsp_valid;

`ifdef YSYX_ARB_RR_EN
    assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || (r_last_grant == c_OWN_IFU));
`else
    assign w_pick_lsu = lsu_req_valid;
`endif

    assign w_grant       = w_idle_free && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = w_idle_free && ifu_req_valid && !w_pick_lsu;
    assign lsu_req_ready = w_idle_free && w_pick_lsu;
    assign w_timeout     = c_WDOG_EN && (r_wdog == c_TO_LAST);

    always_comb begin
        w_rsp_fire = 1'b0;
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        if (r_state == c_ST_WAIT) begin
            if (mem_rsp_valid) begin
                w_rsp_fire = 1'b1;
                w_rsp_data = r_wen ? '0 : mem_rsp_rdata;
                w_rsp_err  = mem_rsp_err;
            end else if (w_timeout) begin
                w_rsp_fire = 1'b1;
                w_rsp_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_owner         <= c_OWN_IFU;
            r_req_valid     <= 1'b0;
            r_wen           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_wdog          <= '0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_data  <= '0;
            r_ifu_rsp_err   <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_rdata <= '0;
            r_lsu_rsp_err   <= 1'b0;
`ifdef YSYX_ARB_RR_EN
            r_last_grant    <= c_OWN_IFU;
`endif
        end else begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_pick_lsu;
                        r_req_valid <= 1'b1;
                        r_state     <= c_ST_ISSUE;
`ifdef YSYX_ARB_RR_EN
                        r_last_grant <= w_pick_lsu;
`endif
                        if (w_pick_lsu) begin
                            r_wen   <= lsu_req_wen;
                            r_addr  <= lsu_req_addr;
                            r_wdata <= lsu_req_wdata;
                            r_wmask <= lsu_req_wmask;
                        end else begin
                            r_wen   <= 1'b0;
                            r_addr  <= ifu_req_addr;
                            r_wdata <= '0;
                            r_wmask <= '0;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_wdog      <= '0;
                        r_state     <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_rsp_fire) begin
                        r_state <= c_ST_IDLE;
                        if (r_owner == c_OWN_LSU) begin
                            r_lsu_rsp_valid <= 1'b1;
                            r_lsu_rsp_rdata <= w_rsp_data;
                            r_lsu_rsp_err   <= w_rsp_err;
                        end else begin
                            r_ifu_rsp_valid <= 1'b1;
                            r_ifu_rsp_data  <= w_rsp_data;
                            r_ifu_rsp_err   <= w_rsp_err;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;

    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign ifu_rsp_data  = r_ifu_rsp_data;
    assign ifu_rsp_err   = r_ifu_rsp_err;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_rdata = r_lsu_rsp_rdata;
    assign lsu_rsp_err   = r_lsu_rsp_err;

endmodule

`default_nettype wire
